// File: rtl/mips16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips16_pkg
// Description : Shared constants and types for the mips_16 core and the
//               instruction-memory loader (IMEM geometry, loader states).
// Revision    : 1.0 - initial release
// ============================================================================
package mips16_pkg;

    // Instruction memory geometry; depth is always a power of two.
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    // Loader FSM encoding.
    typedef enum logic [2:0] {
        LD_LEN_HI  = 3'd0,
        LD_LEN_LO  = 3'd1,
        LD_DATA_HI = 3'd2,
        LD_DATA_LO = 3'd3,
        LD_CHECK   = 3'd4,
        LD_DONE    = 3'd5,
        LD_ERROR   = 3'd6
    } loader_state_t;

    // A state accepts stream bytes unless the load has finished or failed.
    function automatic logic state_accepts(input loader_state_t st);
        return (st != LD_DONE) && (st != LD_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Load-stream handshake, instruction-memory write port and
//               CPU control/status lines of the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if
    import mips16_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);

    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    // Loader side.
    modport slave (
        input  in_valid, in_byte, restart,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    // Stream source / system side.
    modport master (
        output in_valid, in_byte, restart,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a length-prefixed, XOR-checksummed byte stream,
//               writes 16-bit words into instruction memory and releases the
//               CPU from reset once a load with a good checksum completes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import mips16_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    imem_loader_if.slave     bus
);

    loader_state_t     r_state;
    logic              r_in_ready;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_left;      // words still to be received
    logic [ADDR_W-1:0] r_idx;       // word index of the next write
    logic [7:0]        r_chk;       // running XOR of data bytes
    logic [7:0]        r_hi;        // high byte of the word in flight
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic [15:0]       w_len;
    logic              w_len_too_big;

    assign w_accept      = bus.in_valid && r_in_ready;
    assign w_len         = {r_len_hi, bus.in_byte};
    assign w_len_too_big = {16'd0, w_len} > 32'(DEPTH);

    // Load FSM: state, counters, checksum, write port and ready flag.
    // in_ready is registered from the next state so it is low exactly
    // while the FSM sits in DONE or ERROR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= LD_LEN_HI;
            r_in_ready <= 1'b1;
            r_len_hi   <= 8'd0;
            r_left     <= 16'd0;
            r_idx      <= '0;
            r_chk      <= 8'd0;
            r_hi       <= 8'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 16'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                LD_LEN_HI: begin
                    if (w_accept) begin
                        r_len_hi <= bus.in_byte;
                        r_state  <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (w_accept) begin
                        if (w_len == 16'd0) begin
                            r_state <= LD_CHECK;
                        end else if (w_len_too_big) begin
                            r_state    <= LD_ERROR;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_left  <= w_len;
                            r_state <= LD_DATA_HI;
                        end
                    end
                end
                LD_DATA_HI: begin
                    if (w_accept) begin
                        r_hi    <= bus.in_byte;
                        r_chk   <= r_chk ^ bus.in_byte;
                        r_state <= LD_DATA_LO;
                    end
                end
                LD_DATA_LO: begin
                    if (w_accept) begin
                        r_chk   <= r_chk ^ bus.in_byte;
                        r_we    <= 1'b1;
                        r_addr  <= r_idx;
                        r_wdata <= {r_hi, bus.in_byte};
                        r_idx   <= r_idx + 1'b1;
                        r_left  <= r_left - 16'd1;
                        r_state <= (r_left == 16'd1) ? LD_CHECK : LD_DATA_HI;
                    end
                end
                LD_CHECK: begin
                    if (w_accept) begin
                        r_state    <= (bus.in_byte == r_chk) ? LD_DONE : LD_ERROR;
                        r_in_ready <= 1'b0;
                    end
                end
                LD_DONE, LD_ERROR: begin
                    if (bus.restart) begin
                        r_state    <= LD_LEN_HI;
                        r_idx      <= '0;
                        r_chk      <= 8'd0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= LD_ERROR;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs registered from the current state (one cycle behind it).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cpu_reset <= (r_state != LD_DONE);
            r_done      <= (r_state == LD_DONE);
            r_error     <= (r_state == LD_ERROR) || !state_accepts(r_state) && (r_state != LD_DONE);
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;
    import mips16_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(IMEM_ADDR_W)) bus ();

    imem_loader #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (IMEM_ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [IMEM_ADDR_W-1:0] wr_addr[$];
    logic [15:0]            wr_data[$];

    // Log every write strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("ready_wait", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[i]) send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic restart_pulse();
        @(negedge clk);
        bus.restart = 1'b1;
        @(posedge clk);
        #1;
        bus.restart = 1'b0;
    endtask

    // After the final byte: result must appear exactly one cycle later.
    task automatic check_result(input string tag, input logic exp_done);
        check({tag, "_done_early"},  32'(bus.done),  32'd0);
        check({tag, "_error_early"}, 32'(bus.error), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"},      32'(bus.done),      32'(exp_done));
        check({tag, "_error"},     32'(bus.error),     32'(!exp_done));
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!exp_done));
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    endtask

    task automatic check_writes(input string tag, input logic [IMEM_ADDR_W-1:0] ea[$],
                                input logic [15:0] ed[$]);
        check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(ea.size()));
        foreach (ea[i]) begin
            if (i < wr_addr.size()) begin
                check({tag, "_wr_addr"}, 32'(wr_addr[i]), 32'(ea[i]));
                check({tag, "_wr_data"}, 32'(wr_data[i]), 32'(ed[i]));
            end
        end
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]             s[$];
        logic [IMEM_ADDR_W-1:0] ea[$];
        logic [15:0]            ed[$];
        logic [7:0]             x;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.restart  = 1'b0;
        #1;
        check("rst_we",        32'(bus.imem_we),    32'd0);
        check("rst_addr",      32'(bus.imem_addr),  32'd0);
        check("rst_wdata",     32'(bus.imem_wdata), 32'd0);
        check("rst_cpu_reset", 32'(bus.cpu_reset),  32'd1);
        check("rst_done",      32'(bus.done),       32'd0);
        check("rst_error",     32'(bus.error),      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Two words; checksum 12^34^AB^CD = 40.
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_stream(s, 0);
        check_result("two_words", 1'b1);
        check("hold_addr",  32'(bus.imem_addr),  32'd1);
        check("hold_wdata", 32'(bus.imem_wdata), 32'h0000ABCD);
        check("hold_we",    32'(bus.imem_we),    32'd0);
        ea = '{8'd0, 8'd1}; ed = '{16'h1234, 16'hABCD};
        check_writes("two_words", ea, ed);

        // Same payload, wrong checksum: writes stay, load fails.
        restart_pulse();
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h70};
        send_stream(s, 0);
        check_result("bad_chk", 1'b0);
        check_writes("bad_chk", ea, ed);

        // Zero-length load.
        restart_pulse();
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        check_result("zero_len", 1'b1);
        ea = {}; ed = {};
        check_writes("zero_len", ea, ed);

        // Length DEPTH+1 rejected straight after the length bytes.
        restart_pulse();
        s = '{8'h01, 8'h01};
        send_stream(s, 0);
        check("too_long_ready_now", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("too_long_error",     32'(bus.error),     32'd1);
        check("too_long_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("too_long_done",      32'(bus.done),      32'd0);
        check_writes("too_long", ea, ed);

        // Length exactly DEPTH fills the whole memory.
        restart_pulse();
        s = '{8'h01, 8'h00};
        x = 8'h00;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            s.push_back(8'(i));
            s.push_back(~8'(i));
            x = x ^ 8'(i) ^ ~8'(i);
            ea.push_back(IMEM_ADDR_W'(i));
            ed.push_back({8'(i), ~8'(i)});
        end
        s.push_back(x);
        send_stream(s, 0);
        check_result("full_depth", 1'b1);
        check_writes("full_depth", ea, ed);

        // One word, bad checksum (expected 51), then restart.
        restart_pulse();
        s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h00};
        send_stream(s, 0);
        check_result("beef_bad", 1'b0);
        ea = '{8'd0}; ed = '{16'hBEEF};
        check_writes("beef_bad", ea, ed);
        restart_pulse();
        check("restart_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("restart_error",     32'(bus.error),     32'd0);
        check("restart_cpu_reset", 32'(bus.cpu_reset), 32'd1);

        // Two-word load with random idle gaps between bytes.
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_stream(s, 3);
        check_result("gaps", 1'b1);
        ea = '{8'd0, 8'd1}; ed = '{16'h1234, 16'hABCD};
        check_writes("gaps", ea, ed);

        // Reset after the first data byte abandons the load.
        restart_pulse();
        s = '{8'h00, 8'h02, 8'h12};
        send_stream(s, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_we",        32'(bus.imem_we),    32'd0);
        check("midrst_addr",      32'(bus.imem_addr),  32'd0);
        check("midrst_wdata",     32'(bus.imem_wdata), 32'd0);
        check("midrst_cpu_reset", 32'(bus.cpu_reset),  32'd1);
        check("midrst_done",      32'(bus.done),       32'd0);
        check("midrst_error",     32'(bus.error),      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        ea = {}; ed = {};
        check_writes("midrst", ea, ed);
        s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        send_stream(s, 0);
        check_result("after_rst", 1'b1);
        ea = '{8'd0}; ed = '{16'hBEEF};
        check_writes("after_rst", ea, ed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
